// File: rtl/io_pkg.sv
// Shared address map and status/interrupt bit positions for the io_mmio block.
package io_pkg;

  localparam logic [15:0] ADDR_SW        = 16'hFF00;
  localparam logic [15:0] ADDR_KEY       = 16'hFF01;
  localparam logic [15:0] ADDR_LEDR      = 16'hFF02;
  localparam logic [15:0] ADDR_LEDG      = 16'hFF03;
  localparam logic [15:0] ADDR_UART_TXD  = 16'hFF04;
  localparam logic [15:0] ADDR_UART_RXD  = 16'hFF05;
  localparam logic [15:0] ADDR_UART_STAT = 16'hFF06;
  localparam logic [15:0] ADDR_KEY_EVT   = 16'hFF07;
  localparam logic [15:0] ADDR_IRQ_EN    = 16'hFF08;
  localparam logic [15:0] ADDR_SEG_BASE  = 16'hFF10;

  localparam int STAT_RX_VALID   = 0;
  localparam int STAT_TX_BUSY    = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_KEY_ANY    = 3;

  localparam int IRQ_RX_VALID   = 0;
  localparam int IRQ_RX_OVERRUN = 1;
  localparam int IRQ_KEY_ANY    = 2;

  function automatic logic [15:0] seg_addr(input int idx);
    return ADDR_SEG_BASE + 16'(idx);
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// UART receive buffer: DEPTH-entry FIFO when UART_RX_FIFO_EN is defined, otherwise a
// single holding register. A push while full is accepted only if a pop happens that cycle.
module io_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
`else
  localparam int unused_depth = DEPTH;

  logic [7:0] hold;
  logic       hold_vld;

  assign empty = !hold_vld;
  assign full  = hold_vld;
  assign dout  = hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (push && (!hold_vld || pop)) begin
      hold     <= din;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/io_mmio.sv
// Memory-mapped board I/O: LEDs, 7-seg digits, switches, keys, UART tx/rx and irq.
// Read data appears one cycle after re; RX depth is set by UART_RX_FIFO_EN.
module io_mmio
  import io_pkg::*;
#(
  parameter int SW_W     = 10,
  parameter int LEDR_W   = 10,
  parameter int LEDG_W   = 8,
  parameter int NUM_SEG  = 4,
  parameter int RX_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [7:0]           di,
  output logic [7:0]           dout,
  input  logic [SW_W-1:0]      switches,
  input  logic [3:0]           keys,
  output logic [LEDR_W-1:0]    ledr,
  output logic [LEDG_W-1:0]    ledg,
  output logic [7*NUM_SEG-1:0] seg,
  input  logic [7:0]           uart_rxd_data,
  input  logic                 uart_rxd_done,
  input  logic                 uart_txd_done,
  output logic [7:0]           uart_txd_data,
  output logic                 uart_transmit,
  output logic                 irq
);

  logic       rd;
  logic [7:0] sw8;
  logic [6:0] seg_r [NUM_SEG];
  logic       tx_busy;
  logic       txd_wr;
  logic       rx_pop;
  logic       rx_empty;
  logic       rx_full;
  logic [7:0] rx_head;
  logic       rx_valid;
  logic       rx_overrun;
  logic       ovr_set;
  logic       ovr_clr;
  logic [3:0] key_s1;
  logic [3:0] key_s2;
  logic [3:0] key_prev;
  logic [3:0] key_evt;
  logic [3:0] evt_clr;
  logic       key_any;
  logic [2:0] irq_en;
  logic [2:0] irq_src;
  logic       rd_hit;
  logic [7:0] rd_val;

  // A write in the same cycle as a read cancels the read.
  assign rd = re && !we;

  if (SW_W >= 8) begin : g_sw_wide
    assign sw8 = switches[7:0];
    if (SW_W > 8) begin : g_sw_hi
      logic unused_sw_hi;
      assign unused_sw_hi = ^switches[SW_W-1:8];
    end
  end else begin : g_sw_narrow
    assign sw8 = 8'(switches);
  end

  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    assign seg[7*i +: 7] = seg_r[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledr <= '0;
      ledg <= '0;
      for (int i = 0; i < NUM_SEG; i++) seg_r[i] <= 7'h7F;
    end else if (we) begin
      if (addr == ADDR_LEDR) ledr <= LEDR_W'(di);
      if (addr == ADDR_LEDG) ledg <= LEDG_W'(di);
      for (int i = 0; i < NUM_SEG; i++) begin
        if (addr == seg_addr(i)) seg_r[i] <= di[6:0];
      end
    end
  end

  assign txd_wr = we && (addr == ADDR_UART_TXD) && !tx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_txd_data <= '0;
      uart_transmit <= 1'b0;
      tx_busy       <= 1'b0;
    end else begin
      uart_transmit <= txd_wr;
      if (txd_wr) begin
        uart_txd_data <= di;
        tx_busy       <= 1'b1;
      end else if (uart_txd_done) begin
        tx_busy <= 1'b0;
      end
    end
  end

  assign rx_pop   = rd && (addr == ADDR_UART_RXD);
  assign rx_valid = !rx_empty;

  io_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rxd_done),
    .pop   (rx_pop),
    .din   (uart_rxd_data),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // A pop while full frees the slot the incoming byte needs, so no overrun.
  assign ovr_set = uart_rxd_done && rx_full && !rx_pop;
  assign ovr_clr = we && (addr == ADDR_UART_STAT) && di[STAT_RX_OVERRUN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overrun <= 1'b0;
    else if (ovr_set) rx_overrun <= 1'b1;
    else if (ovr_clr) rx_overrun <= 1'b0;
  end

  assign evt_clr = (we && (addr == ADDR_KEY_EVT)) ? di[3:0] : 4'h0;
  assign key_any = |key_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1   <= 4'hF;
      key_s2   <= 4'hF;
      key_prev <= 4'hF;
      key_evt  <= 4'h0;
    end else begin
      key_s1   <= keys;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      key_evt  <= (key_evt & ~evt_clr) | (key_prev & ~key_s2);
    end
  end

  always_comb begin
    irq_src                 = '0;
    irq_src[IRQ_RX_VALID]   = rx_valid;
    irq_src[IRQ_RX_OVERRUN] = rx_overrun;
    irq_src[IRQ_KEY_ANY]    = key_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (we && (addr == ADDR_IRQ_EN)) irq_en <= di[2:0];
      irq <= |(irq_en & irq_src);
    end
  end

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (addr)
      ADDR_SW:       rd_val = sw8;
      ADDR_KEY:      rd_val = {4'h0, key_s2};
      ADDR_UART_RXD: rd_val = rx_empty ? 8'h00 : rx_head;
      ADDR_UART_STAT: begin
        rd_val[STAT_RX_VALID]   = rx_valid;
        rd_val[STAT_TX_BUSY]    = tx_busy;
        rd_val[STAT_RX_OVERRUN] = rx_overrun;
        rd_val[STAT_KEY_ANY]    = key_any;
      end
      ADDR_KEY_EVT:  rd_val = {4'h0, key_evt};
      ADDR_IRQ_EN:   rd_val = {5'h0, irq_en};
      default:       rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else     dout <= (rd && rd_hit) ? rd_val : 8'h00;
  end

endmodule

// File: tb/tb_io_mmio.sv
// Randomised and directed checks of io_mmio against a register/queue-level model.
module tb_io_mmio;
  import io_pkg::*;

  localparam int SW_W     = 10;
  localparam int LEDR_W   = 10;
  localparam int LEDG_W   = 8;
  localparam int NUM_SEG  = 4;
  localparam int RX_DEPTH = 8;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = RX_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [15:0]          addr;
  logic                 we, re;
  logic [7:0]           di;
  logic [7:0]           dout;
  logic [SW_W-1:0]      switches;
  logic [3:0]           keys;
  logic [LEDR_W-1:0]    ledr;
  logic [LEDG_W-1:0]    ledg;
  logic [7*NUM_SEG-1:0] seg;
  logic [7:0]           uart_rxd_data;
  logic                 uart_rxd_done, uart_txd_done;
  logic [7:0]           uart_txd_data;
  logic                 uart_transmit;
  logic                 irq;

  io_mmio #(.SW_W(SW_W), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W), .NUM_SEG(NUM_SEG),
            .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .di(di), .dout(dout),
    .switches(switches), .keys(keys), .ledr(ledr), .ledg(ledg), .seg(seg),
    .uart_rxd_data(uart_rxd_data), .uart_rxd_done(uart_rxd_done),
    .uart_txd_done(uart_txd_done), .uart_txd_data(uart_txd_data),
    .uart_transmit(uart_transmit), .irq(irq));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [LEDR_W-1:0] m_ledr;
  logic [LEDG_W-1:0] m_ledg;
  logic [6:0]        m_seg [NUM_SEG];
  logic [7:0]        m_txd;
  logic              m_busy, m_ovr;
  logic [3:0]        m_evt;
  logic [2:0]        m_irqen;
  logic [3:0]        kh [3];   // key inputs seen at the last three edges, newest first
  logic [7:0]        q[$];

  task automatic model_reset();
    m_ledr = '0; m_ledg = '0; m_txd = '0; m_busy = 0; m_ovr = 0; m_evt = '0; m_irqen = '0;
    for (int i = 0; i < NUM_SEG; i++) m_seg[i] = 7'h7F;
    for (int i = 0; i < 3; i++) kh[i] = 4'hF;
    q.delete();
  endtask

  // One clock: predict from current inputs and model, advance, then compare.
  task automatic step();
    logic [7:0]           n_do = 8'h00;
    logic                 n_irq, n_tx, pop = 0, full, ovr_set = 0;
    logic [3:0]           set, clr = 4'h0;
    logic [7*NUM_SEG-1:0] exp_seg;
    n_irq = (m_irqen[2] && m_evt != 0) || (m_irqen[1] && m_ovr) || (m_irqen[0] && q.size() > 0);
    if (re && !we) begin
      case (addr)
        ADDR_SW:        n_do = switches[7:0];
        ADDR_KEY:       n_do = {4'h0, kh[1]};
        ADDR_UART_RXD:  if (q.size() > 0) begin n_do = q[0]; pop = 1; end
        ADDR_UART_STAT: n_do = {4'h0, (m_evt != 0), m_ovr, m_busy, (q.size() > 0)};
        ADDR_KEY_EVT:   n_do = {4'h0, m_evt};
        ADDR_IRQ_EN:    n_do = {5'h0, m_irqen};
        default:        n_do = 8'h00;
      endcase
    end
    n_tx = we && addr == ADDR_UART_TXD && !m_busy;
    if (n_tx) begin m_txd = di; m_busy = 1; end
    else if (uart_txd_done) m_busy = 0;
    if (we) begin
      if (addr == ADDR_LEDR) m_ledr = {2'b00, di};
      if (addr == ADDR_LEDG) m_ledg = di;
      if (addr == ADDR_IRQ_EN) m_irqen = di[2:0];
      if (addr == ADDR_KEY_EVT) clr = di[3:0];
      for (int i = 0; i < NUM_SEG; i++)
        if (addr == ADDR_SEG_BASE + 16'(i)) m_seg[i] = di[6:0];
    end
    full = (q.size() == CAP);
    if (pop) void'(q.pop_front());
    if (uart_rxd_done) begin
      if (!full || pop) q.push_back(uart_rxd_data);
      else ovr_set = 1;
    end
    if (ovr_set) m_ovr = 1;
    else if (we && addr == ADDR_UART_STAT && di[2]) m_ovr = 0;
    set = kh[2] & ~kh[1];
    m_evt = (m_evt & ~clr) | set;
    kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = keys;

    @(posedge clk); #1;
    for (int i = 0; i < NUM_SEG; i++) exp_seg[7*i +: 7] = m_seg[i];
    check("do", dout, n_do);
    check("transmit", uart_transmit, n_tx);
    check("irq", irq, n_irq);
    check("txd_data", uart_txd_data, m_txd);
    check("ledr", ledr, m_ledr);
    check("ledg", ledg, m_ledg);
    check("seg", seg, exp_seg);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; di = d; we = 1; step(); we = 0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] got);
    addr = a; re = 1; step(); got = dout; re = 0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    uart_rxd_data = b; uart_rxd_done = 1; step(); uart_rxd_done = 0;
  endtask

  task automatic txd_done_pulse();
    uart_txd_done = 1; step(); uart_txd_done = 0;
  endtask

  logic [15:0] atbl [13];

  initial begin
    logic [7:0] got;
    int         cnt;
    bit         seen;

    atbl = '{ADDR_SW, ADDR_KEY, ADDR_LEDR, ADDR_LEDG, ADDR_UART_TXD, ADDR_UART_RXD,
             ADDR_UART_STAT, ADDR_KEY_EVT, ADDR_IRQ_EN, ADDR_SEG_BASE,
             ADDR_SEG_BASE + 16'd3, ADDR_SEG_BASE + 16'd4, 16'h0000};
    rst = 1; addr = '0; we = 0; re = 0; di = '0; switches = '0; keys = 4'hF;
    uart_rxd_data = '0; uart_rxd_done = 0; uart_txd_done = 0;
    #12;
    check("rst_ledr", ledr, 0);
    check("rst_ledg", ledg, 0);
    check("rst_seg", seg, 28'hFFFFFFF);
    check("rst_txd", uart_txd_data, 0);
    check("rst_transmit", uart_transmit, 0);
    check("rst_irq", irq, 0);
    check("rst_do", dout, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;

    // LED write, write-only for reads
    bus_write(ADDR_LEDR, 8'h5A);
    check("ledr_5a", ledr, 10'h05A);
    bus_read(ADDR_LEDR, got);
    check("ledr_rd_undecoded", got, 8'h00);
    bus_write(ADDR_SEG_BASE + 16'd4, 8'h00);

    // Transmit
    bus_write(ADDR_UART_TXD, 8'h41);
    check("txd_41", uart_txd_data, 8'h41);
    check("txd_pulse", uart_transmit, 1);
    step();
    check("txd_pulse_end", uart_transmit, 0);
    bus_write(ADDR_UART_TXD, 8'h42);
    check("txd_busy_ignore", uart_txd_data, 8'h41);
    txd_done_pulse();
    bus_read(ADDR_UART_STAT, got);
    check("txd_done_busy", got[1], 0);

    // RX buffer overrun and drain
    for (int i = 1; i <= 9; i++) rx_push(8'(i));
    bus_read(ADDR_UART_STAT, got);
    check("rx_stat_full", got, 8'h05);
    for (int i = 0; i < 8; i++) begin
      bus_read(ADDR_UART_RXD, got);
      check("rx_drain", got, (i < CAP) ? 8'(i + 1) : 8'h00);
    end
    bus_read(ADDR_UART_RXD, got);
    check("rx_empty_read", got, 8'h00);
    bus_read(ADDR_UART_STAT, got);
    check("rx_empty_valid", got[0], 0);
    bus_write(ADDR_UART_STAT, 8'h04);

    // Simultaneous push and pop while full
    for (int i = 0; i < CAP; i++) rx_push(8'hA0 + 8'(i));
    addr = ADDR_UART_RXD; re = 1; uart_rxd_data = 8'hEE; uart_rxd_done = 1;
    step();
    re = 0; uart_rxd_done = 0;
    check("pushpop_head", dout, 8'hA0);
    bus_read(ADDR_UART_STAT, got);
    check("pushpop_no_ovr", got[2], 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus_read(ADDR_UART_STAT, got);
      if (!got[0]) break;
      bus_read(ADDR_UART_RXD, got);
      cnt++;
    end
    check("pushpop_count", cnt, CAP);

    // Key falling edge to interrupt
    bus_write(ADDR_IRQ_EN, 8'h04);
    keys = 4'b1101;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      seen = irq;
    end
    check("key_irq_seen", seen, 1);
    bus_read(ADDR_KEY_EVT, got);
    check("key_evt", got, 8'h02);
    bus_write(ADDR_KEY_EVT, 8'h02);
    step();
    check("key_irq_clear", irq, 0);
    keys = 4'hF;

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      addr = atbl[$urandom_range(0, 12)];
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 2) == 0);
      di = 8'($urandom);
      switches = SW_W'($urandom);
      uart_rxd_data = 8'($urandom);
      uart_rxd_done = ($urandom_range(0, 3) == 0);
      uart_txd_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) keys = 4'($urandom);
      step();
    end
    we = 0; re = 0; uart_rxd_done = 0; uart_txd_done = 0; keys = 4'hF;
    for (int i = 0; i < 4; i++) step();

    // Reset in the middle of a transmit
    txd_done_pulse();
    bus_write(ADDR_UART_TXD, 8'h77);
    #2 rst = 1;
    #1;
    check("mid_rst_ledr", ledr, 0);
    check("mid_rst_ledg", ledg, 0);
    check("mid_rst_seg", seg, 28'hFFFFFFF);
    check("mid_rst_txd", uart_txd_data, 0);
    check("mid_rst_transmit", uart_transmit, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_do", dout, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    txd_done_pulse();
    bus_read(ADDR_UART_STAT, got);
    check("mid_rst_busy", got[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
